// File: rtl/jk_sync_counter.sv
// Mod-N up/down counter built from JK flip-flop cells.
// Exports per-bit J/K excitation alongside q, qb and terminal count.

module jk_cell (
  input  logic       clk,
  input  logic [1:0] jk,
  output logic       q,
  output logic       qb
);

  always_ff @(posedge clk) begin
    case (jk)
      2'b00:   q <= q;
      2'b01:   q <= 1'b0;
      2'b10:   q <= 1'b1;
      default: q <= ~q;
    endcase
  end

  assign qb = ~q;

endmodule

module jk_sync_counter #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic [WIDTH-1:0]   din,
  output logic [WIDTH-1:0]   q,
  output logic [WIDTH-1:0]   qb,
  output logic               tc,
  output logic [2*WIDTH-1:0] jk
);

  if (MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_mod
    $error("jk_sync_counter: MODULUS out of range");
  end

  localparam logic [WIDTH-1:0] MAX =
    WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] nxt_cnt;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] tgl;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;

  logic sel_rst;
  logic sel_ld;
  logic sel_cnt;
  logic at_max;
  logic at_zero;

  assign at_max  = (q == MAX);
  assign at_zero = (q == '0);

  // out-of-range states wrap to zero when counting up
  always_comb begin
    nxt_cnt = q;
    if (up) begin
      if (q >= MAX) nxt_cnt = '0;
      else          nxt_cnt = q + 1'b1;
    end else begin
      if (at_zero)  nxt_cnt = MAX;
      else          nxt_cnt = q - 1'b1;
    end
  end

  assign ld_val = (din <= MAX) ? din : '0;
  assign tgl    = nxt_cnt ^ q;

  assign sel_rst = rst;
  assign sel_ld  = ~rst & load;
  assign sel_cnt = ~rst & ~load & en;

  always_comb begin
    j = '0;
    k = '0;
    unique case (1'b1)
      sel_rst: begin
        j = '0;
        k = '1;
      end
      sel_ld: begin
        j = ld_val;
        k = ~ld_val;
      end
      sel_cnt: begin
        j = tgl;
        k = tgl;
      end
      default: begin
        j = '0;
        k = '0;
      end
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign jk[2*i+1] = j[i];
    assign jk[2*i]   = k[i];

    jk_cell u_cell (
      .clk (clk),
      .jk  (jk[2*i +: 2]),
      .q   (q[i]),
      .qb  (qb[i])
    );
  end

  assign tc = sel_cnt &
              (up ? at_max : at_zero);

endmodule

// File: tb/tb_jk_sync_counter.sv
// Bench for jk_sync_counter: mod-10 and mod-16 builds
// driven together, checked against an arithmetic model.

module tb_jk_sync_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       load = 1'b0;
  logic [3:0] din = '0;

  logic [3:0] q10, qb10, q16, qb16;
  logic       tc10, tc16;
  logic [7:0] jk10, jk16;

  int checks = 0;
  int errors = 0;

  int m10 = 0;
  int m16 = 0;

  logic [7:0] sjk10, sjk16, ejk10, ejk16;
  logic       stc10, stc16, etc10, etc16;
  int         pre10, pre16;

  always #5 clk = ~clk;

  jk_sync_counter #(.WIDTH(4), .MODULUS(10)) dut10 (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .din(din), .q(q10), .qb(qb10),
    .tc(tc10), .jk(jk10)
  );

  jk_sync_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .rst(rst), .en(en), .up(up),
    .load(load), .din(din), .q(q16), .qb(qb16),
    .tc(tc16), .jk(jk16)
  );

  function automatic int mnext(int m, int md, bit r,
                               bit l, bit e, bit u, int d);
    if (r) return 0;
    if (l) return (d < md) ? d : 0;
    if (e) begin
      if (u) return (m + 1) % md;
      return (m + md - 1) % md;
    end
    return m;
  endfunction

  function automatic logic [7:0] mjk(int m, int md, bit r,
                                     bit l, bit e, bit u, int d);
    int n;
    logic [7:0] v;
    n = mnext(m, md, r, l, e, u, d);
    v = '0;
    for (int i = 0; i < 4; i++) begin
      if (r)      v[2*i +: 2] = 2'b01;
      else if (l) v[2*i +: 2] = {n[i], ~n[i]};
      else if (e) v[2*i +: 2] = {2{n[i] ^ m[i]}};
      else        v[2*i +: 2] = 2'b00;
    end
    return v;
  endfunction

  function automatic bit mtc(int m, int md, bit r,
                             bit l, bit e, bit u);
    return e && !l && !r && (u ? (m == md - 1) : (m == 0));
  endfunction

  task automatic tick(input bit r, input bit l, input bit e,
                      input bit u, input logic [3:0] d);
    rst = r; load = l; en = e; up = u; din = d;
    pre10 = m10;
    pre16 = m16;
    ejk10 = mjk(m10, 10, r, l, e, u, int'(d));
    ejk16 = mjk(m16, 16, r, l, e, u, int'(d));
    etc10 = mtc(m10, 10, r, l, e, u);
    etc16 = mtc(m16, 16, r, l, e, u);
    @(negedge clk);
    sjk10 = jk10; stc10 = tc10;
    sjk16 = jk16; stc16 = tc16;
    @(posedge clk);
    #1;
    m10 = mnext(m10, 10, r, l, e, u, int'(d));
    m16 = mnext(m16, 16, r, l, e, u, int'(d));
  endtask

  task automatic test_reset;
    tick(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
    checks++;
    if (q10 !== 4'd0) begin
      errors++;
      $display("FAIL reset_q got %h want 0", q10);
    end
    checks++;
    if (qb10 !== 4'hF) begin
      errors++;
      $display("FAIL reset_qb got %h want f", qb10);
    end
    checks++;
    if (stc10 !== 1'b0) begin
      errors++;
      $display("FAIL reset_tc got %b want 0", stc10);
    end
    checks++;
    if (sjk10 !== 8'b01010101) begin
      errors++;
      $display("FAIL reset_jk got %b want 01010101", sjk10);
    end
    checks++;
    if (q16 !== 4'd0 || qb16 !== 4'hF) begin
      errors++;
      $display("FAIL reset_q16 got %h/%h want 0/f", q16, qb16);
    end
  endtask

  task automatic test_up_wrap;
    for (int s = 1; s <= 12; s++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
      checks++;
      if (q10 !== 4'(s % 10)) begin
        errors++;
        $display("FAIL up_q step %0d got %0d want %0d",
                 s, q10, s % 10);
      end
      checks++;
      if (stc10 !== (pre10 == 9)) begin
        errors++;
        $display("FAIL up_tc from %0d got %b want %b",
                 pre10, stc10, pre10 == 9);
      end
      checks++;
      if (sjk10 !== ejk10) begin
        errors++;
        $display("FAIL up_jk from %0d got %b want %b",
                 pre10, sjk10, ejk10);
      end
      if (pre10 == 7) begin
        checks++;
        if (sjk10 !== 8'b11111111) begin
          errors++;
          $display("FAIL up_jk7 got %b want 11111111", sjk10);
        end
      end
    end
  endtask

  task automatic test_down_wrap;
    int exp_seq[3] = '{0, 9, 8};
    tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd1);
    checks++;
    if (q10 !== 4'd1) begin
      errors++;
      $display("FAIL dn_load got %0d want 1", q10);
    end
    for (int s = 0; s < 3; s++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
      checks++;
      if (q10 !== 4'(exp_seq[s])) begin
        errors++;
        $display("FAIL dn_q step %0d got %0d want %0d",
                 s, q10, exp_seq[s]);
      end
      checks++;
      if (stc10 !== (pre10 == 0)) begin
        errors++;
        $display("FAIL dn_tc from %0d got %b want %b",
                 pre10, stc10, pre10 == 0);
      end
      if (pre10 == 0) begin
        checks++;
        if (sjk10 !== 8'b11000011) begin
          errors++;
          $display("FAIL dn_jk0 got %b want 11000011", sjk10);
        end
      end
    end
  endtask

  task automatic test_load;
    tick(1'b0, 1'b1, 1'b1, 1'b1, 4'd6);
    checks++;
    if (sjk10 !== 8'b01101001) begin
      errors++;
      $display("FAIL ld_jk got %b want 01101001", sjk10);
    end
    checks++;
    if (q10 !== 4'd6 || stc10 !== 1'b0) begin
      errors++;
      $display("FAIL ld_q got %0d/%b want 6/0", q10, stc10);
    end
    tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd12);
    checks++;
    if (q10 !== 4'd0 || sjk10 !== 8'b01010101) begin
      errors++;
      $display("FAIL ld_big got %0d/%b want 0/01010101",
               q10, sjk10);
    end
    checks++;
    if (q16 !== 4'd12) begin
      errors++;
      $display("FAIL ld_16 got %0d want 12", q16);
    end
  endtask

  task automatic test_hold_priority;
    tick(1'b0, 1'b1, 1'b0, 1'b1, 4'd4);
    for (int s = 0; s < 3; s++) begin
      tick(1'b0, 1'b0, 1'b0, s[0], 4'(s + 7));
      checks++;
      if (q10 !== 4'd4 || sjk10 !== 8'd0 || stc10 !== 1'b0) begin
        errors++;
        $display("FAIL hold step %0d got %0d/%b/%b want 4/0/0",
                 s, q10, sjk10, stc10);
      end
    end
    tick(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
    checks++;
    if (q10 !== 4'd0 || q16 !== 4'd0) begin
      errors++;
      $display("FAIL rst_over_ld got %0d/%0d want 0/0", q10, q16);
    end
  endtask

  task automatic test_boundary;
    tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd15);
    checks++;
    if (q16 !== 4'd15 || q10 !== 4'd0) begin
      errors++;
      $display("FAIL bd_load got %0d/%0d want 15/0", q16, q10);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
    checks++;
    if (q16 !== 4'd0 || stc16 !== 1'b1 || sjk16 !== 8'hFF) begin
      errors++;
      $display("FAIL bd_up got %0d/%b/%b want 0/1/11111111",
               q16, stc16, sjk16);
    end
    tick(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
    checks++;
    if (q16 !== 4'd15 || stc16 !== 1'b1 || sjk16 !== 8'hFF) begin
      errors++;
      $display("FAIL bd_dn got %0d/%b/%b want 15/1/11111111",
               q16, stc16, sjk16);
    end
  endtask

  task automatic test_random;
    bit r, l, e, u;
    logic [3:0] d;
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(31) == 0);
      l = ($urandom_range(5) == 0);
      e = ($urandom_range(3) != 0);
      u = $urandom_range(1);
      d = 4'($urandom_range(15));
      tick(r, l, e, u, d);
      checks++;
      if (sjk10 !== ejk10 || stc10 !== etc10) begin
        errors++;
        $display("FAIL rnd10_comb it %0d got %b/%b want %b/%b",
                 n, sjk10, stc10, ejk10, etc10);
      end
      checks++;
      if (q10 !== 4'(m10) || qb10 !== ~4'(m10)) begin
        errors++;
        $display("FAIL rnd10_q it %0d got %0d/%h want %0d",
                 n, q10, qb10, m10);
      end
      checks++;
      if (sjk16 !== ejk16 || stc16 !== etc16) begin
        errors++;
        $display("FAIL rnd16_comb it %0d got %b/%b want %b/%b",
                 n, sjk16, stc16, ejk16, etc16);
      end
      checks++;
      if (q16 !== 4'(m16) || qb16 !== ~4'(m16)) begin
        errors++;
        $display("FAIL rnd16_q it %0d got %0d/%h want %0d",
                 n, q16, qb16, m16);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_hold_priority();
    test_boundary();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/jk_sync_counter.md
# jk_sync_counter

Synchronous mod-N up/down counter whose state bits are held in JK flip-flop cells, with per-bit J/K excitation computed from current state and control inputs. It is the consumer stage that follows the single JK_flipflop cell: it instantiates WIDTH JK cells and drives their jk inputs. The excitation bus is also exported, so a bench or downstream block can check every cell's J/K drive each cycle. Used as the standard counting primitive for lab sequencers and dividers.

## Interface
- WIDTH, 4, number of state bits / JK cells.
- MODULUS, 10, count range 0..MODULUS-1. Legal range is 2 ≤ MODULUS ≤ 2^WIDTH; other values are illegal and elaboration must stop with an error.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable.
- up  input  1  direction: 1 = increment, 0 = decrement.
- load  input  1  synchronous parallel load of din.
- din  input  WIDTH  load value.
- q  output  WIDTH  counter state (JK cell q outputs).
- qb  output  WIDTH  bitwise complement of q (JK cell qb outputs).
- tc  output  1  terminal count, combinational.
- jk  output  2*WIDTH  excitation bus. jk[2i+1] = J of bit i and jk[2i] = K of bit i, i.e. {J,K} per bit, matching the cell's jk[1:0] order.

## Operation
- Control priority: rst > load > en > hold.
- rst=1: every bit gets J=0, K=1 (jk = 01 per bit). After the edge, q=0 and qb=all ones.
- load=1 (rst=0):
  - If din < MODULUS: bit i gets J=din[i], K=~din[i], and q=din after the edge.
  - If din ≥ MODULUS: the load value becomes 0 (J=0, K=1 all bits), and q=0 after the edge.
  - en and up are ignored.
- en=1, up=1 (rst=0, load=0): next = q+1. If q==MODULUS-1, next = 0 (wrap).
- en=1, up=0: next = q-1. If q==0, next = MODULUS-1 (wrap).
- Counting excitation: per bit, J=K=(next[i] XOR q[i]). Toggle bits get 11, all other bits get 00. Counting never uses 01 or 10.
- Hold (en=0, load=0, rst=0): every bit gets jk=00 and q is unchanged.
- State outside 0..MODULUS-1 can only occur through a fault. It is not reachable via load. If it occurs:
  - Up-count treats it as the wrap point: next = 0.
  - Down-count computes q-1 normally.
- tc = en & ~load & ~rst & (up ? q==MODULUS-1 : q==0).
- qb is always ~q, including during and after reset.
- All arithmetic is unsigned, WIDTH bits. The compare against MODULUS-1 uses a WIDTH-bit constant.

## Timing
- Latency: a control/din change before edge N is reflected on q immediately after edge N. That is one clock; there is no pipelining.
- jk and tc are combinational from q, en, up, load, din and rst. They settle within the same cycle and are valid before the rising edge.
- Reset value: at the first edge with rst=1, q=0, qb=all ones. tc=0 while rst=1. jk = {WIDTH{2'b01}} while rst=1.
- Reset asserted mid-count: takes effect at the next edge and overrides a simultaneous load or en.
- Release: on the first edge with rst=0 and en=1, up=1, the count moves 0→1.
- A simultaneous load and en gives the loaded value; no count occurs that cycle.
- Wrap happens on the same edge at which tc=1 is sampled.
- Before the first reset edge, q is X. The bench must not check outputs until after that edge.

## Test plan
- Reset: rst=1 for 2 edges with en=1, load=1, din=5 → q=0, qb=4'hF, tc=0, jk=8'b01010101.
- Up wrap (MODULUS=10): reset, then en=1, up=1 for 12 edges → q = 1..9, 0, 1, 2. tc=1 exactly when q=9. At q=7, jk=8'b11111111 (0111→1000).
- Down wrap: load din=1, then en=1, up=0 → q = 0, 9, 8. tc=1 when q=0. At q=0, jk={11,00,00,11} (bit3..bit0, 0000→1001).
- Load: din=6 with en=1 → q=6 and jk=8'b01101001 during the load cycle. Then din=12 (≥ MODULUS) → q=0.
- Hold/priority: at q=4, en=0 for 3 edges → q stays 4 and jk=0. Then rst=1 together with load=1, din=3 → q=0.
- Boundary build: WIDTH=4, MODULUS=16 → up-count 15→0 and down-count 0→15, with tc on each.
